// File: rtl/signed_fxp_mult_pipe.sv
// Three-stage signed fixed-point multiplier with FRAC rescale, optional round-half-up
// and output saturation, wrapped in a valid/ready pipeline with bubble collapse.
module signed_fxp_mult_pipe #(
   parameter int DW   = 9,
   parameter int FRAC = 6,
   parameter int OW   = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   input  logic                 rnd_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] y,
   output logic                 sat
);

   localparam int PW      = 2 * DW + 1;
   localparam int BIASPOS = (FRAC > 0) ? FRAC - 1 : 0;
   localparam logic signed [PW-1:0] BIAS = (FRAC > 0) ? (PW'(1) << BIASPOS) : '0;
   localparam logic signed [PW-1:0] YMAX = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [PW-1:0] YMIN = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   logic adv1, adv2, adv3;

   logic                   v1_q, v1_d;
   logic signed [DW-1:0]   a1_q, a1_d;
   logic signed [DW-1:0]   b1_q, b1_d;
   logic                   rnd1_q, rnd1_d;

   logic                   v2_q, v2_d;
   logic signed [2*DW-1:0] p2_q, p2_d;
   logic                   rnd2_q, rnd2_d;

   logic                   v3_q, v3_d;
   logic signed [OW-1:0]   y3_q, y3_d;
   logic                   sat3_q, sat3_d;

   logic signed [PW-1:0]   sum3;
   logic signed [PW-1:0]   r3;

   // A stage moves when it is empty or its successor moves, so bubbles are squeezed out
   always_comb begin
      adv3     = ~v3_q | out_ready;
      adv2     = ~v2_q | adv3;
      adv1     = ~v1_q | adv2;
      in_ready = adv1;
   end

   always_comb begin
      v1_d   = v1_q;
      a1_d   = a1_q;
      b1_d   = b1_q;
      rnd1_d = rnd1_q;
      if (adv1) begin
         v1_d = in_valid;
         if (in_valid) begin
            a1_d   = a;
            b1_d   = b;
            rnd1_d = rnd_mode;
         end
      end
   end

   // Operands are widened before multiplying so the most negative square stays exact
   always_comb begin
      v2_d   = v2_q;
      p2_d   = p2_q;
      rnd2_d = rnd2_q;
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            p2_d   = (2*DW)'(a1_q) * (2*DW)'(b1_q);
            rnd2_d = rnd1_q;
         end
      end
   end

   always_comb begin
      sum3   = PW'(p2_q) + (rnd2_q ? BIAS : '0);
      r3     = sum3 >>> FRAC;
      v3_d   = v3_q;
      y3_d   = y3_q;
      sat3_d = sat3_q;
      if (adv3) begin
         v3_d = v2_q;
         if (v2_q) begin
            if (r3 > YMAX) begin
               y3_d   = YMAX[OW-1:0];
               sat3_d = 1'b1;
            end else if (r3 < YMIN) begin
               y3_d   = YMIN[OW-1:0];
               sat3_d = 1'b1;
            end else begin
               y3_d   = r3[OW-1:0];
               sat3_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         y3_q   <= '0;
         sat3_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         a1_q   <= a1_d;
         b1_q   <= b1_d;
         rnd1_q <= rnd1_d;
         v2_q   <= v2_d;
         p2_q   <= p2_d;
         rnd2_q <= rnd2_d;
         v3_q   <= v3_d;
         y3_q   <= y3_d;
         sat3_q <= sat3_d;
      end
   end

   assign out_valid = v3_q;
   assign y         = y3_q;
   assign sat       = sat3_q & v3_q;

endmodule

// File: tb/tb_signed_fxp_mult_pipe.sv
// Bench for signed_fxp_mult_pipe: directed vectors, randomized backpressure stream,
// bubble collapse and mid-stream reset, checked against an arithmetic reference model.
module tb_signed_fxp_mult_pipe;

   localparam int DW   = 9;
   localparam int FRAC = 6;
   localparam int OW   = 9;
   localparam int OW2  = 18;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  out_ready;
   logic                  rnd_mode;
   logic signed [DW-1:0]  a;
   logic signed [DW-1:0]  b;
   logic                  in_ready, out_valid, sat;
   logic signed [OW-1:0]  y;
   logic                  in_ready2, out_valid2, sat2;
   logic signed [OW2-1:0] y2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int     a;
      int     b;
      logic   rnd;
      longint y9;
      logic   sat9;
      longint y18;
      logic   sat18;
   } vec_t;

   typedef struct {
      longint y;
      logic   s;
   } exp_t;

   vec_t   vecs[12];
   exp_t   expQ[$];
   logic   prevStalled;
   longint prevY;
   logic   prevSat;
   int     popped;

   signed_fxp_mult_pipe #(.DW(DW), .FRAC(FRAC), .OW(OW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .sat(sat)
   );

   signed_fxp_mult_pipe #(.DW(DW), .FRAC(FRAC), .OW(OW2)) dutWide (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid2),
      .out_ready(out_ready), .y(y2), .sat(sat2)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: exact product, optional half-LSB bias, floor division, clamp
   function automatic void refModel(input int av, input int bv, input logic rv, input int ow,
                                    output longint yv, output logic sv);
      longint p, d, q, hi, lo;
      p = longint'(av) * longint'(bv);
      d = longint'(1) << FRAC;
      if (rv && FRAC > 0) p = p + d / 2;
      q = p / d;
      if ((p % d) != 0 && p < 0) q = q - 1;
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -hi - 1;
      if (q > hi) begin
         yv = hi; sv = 1'b1;
      end else if (q < lo) begin
         yv = lo; sv = 1'b1;
      end else begin
         yv = q; sv = 1'b0;
      end
   endfunction

   // One isolated transaction into an empty pipe; reports result and latency in edges
   task automatic applyStimulus(input int av, input int bv, input logic rv,
                                output longint yv, output logic sv,
                                output longint y2v, output logic s2v, output int lat);
      bit done = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; a = DW'(av); b = DW'(bv); rnd_mode = rv; out_ready = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_idle", 64'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         if (out_valid) done = 1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      yv = longint'(y); sv = sat; y2v = longint'(y2); s2v = sat2;
      prevStalled = 1'b0;
   endtask

   // One clock of streaming: drive, then check handshake/outputs against the model queue
   task automatic stepCycle(input logic iv, input int av, input int bv, input logic rv,
                            input logic ordy, output logic acc);
      longint ey;
      logic   es;
      exp_t   e;
      @(posedge clk); #1;
      in_valid = iv; a = DW'(av); b = DW'(bv); rnd_mode = rv; out_ready = ordy;
      @(negedge clk);
      checkOutput("in_ready_rule", 64'(in_ready), (expQ.size() == 3 && !ordy) ? 0 : 1);
      if (prevStalled) begin
         checkOutput("hold_valid", 64'(out_valid), 1);
         checkOutput("hold_y", longint'(y), prevY);
         checkOutput("hold_sat", 64'(sat), 64'(prevSat));
      end
      if (expQ.size() == 0) begin
         checkOutput("spurious_valid", 64'(out_valid), 0);
      end else if (out_valid && ordy) begin
         e = expQ.pop_front();
         popped++;
         checkOutput("stream_y", longint'(y), e.y);
         checkOutput("stream_sat", 64'(sat), 64'(e.s));
      end
      acc = iv && in_ready;
      if (acc) begin
         refModel(av, bv, rv, OW, ey, es);
         e.y = ey; e.s = es;
         expQ.push_back(e);
      end
      prevStalled = out_valid && !ordy;
      prevY       = longint'(y);
      prevSat     = sat;
   endtask

   initial begin
      longint yv, y2v;
      logic   sv, s2v, acc;
      int     lat, idx, guard;
      int     sa[20], sb[20];
      logic   sr[20];

      vecs[0]  = '{64,    64,  1'b0,   64, 1'b0,    64, 1'b0};
      vecs[1]  = '{96,   -32,  1'b0,  -48, 1'b0,   -48, 1'b0};
      vecs[2]  = '{1,     32,  1'b0,    0, 1'b0,     0, 1'b0};
      vecs[3]  = '{1,     32,  1'b1,    1, 1'b0,     1, 1'b0};
      vecs[4]  = '{-1,    32,  1'b0,   -1, 1'b0,    -1, 1'b0};
      vecs[5]  = '{-1,    32,  1'b1,    0, 1'b0,     0, 1'b0};
      vecs[6]  = '{-1,   -64,  1'b0,    1, 1'b0,     1, 1'b0};
      vecs[7]  = '{-1,   -64,  1'b1,    1, 1'b0,     1, 1'b0};
      vecs[8]  = '{-256, -256, 1'b0,  255, 1'b1,  1024, 1'b0};
      vecs[9]  = '{-256,  255, 1'b0, -256, 1'b1, -1020, 1'b0};
      vecs[10] = '{255,    64, 1'b0,  255, 1'b0,   255, 1'b0};
      vecs[11] = '{255,   255, 1'b1,  255, 1'b1,  1016, 1'b0};

      prevStalled = 1'b0; prevY = 0; prevSat = 1'b0; popped = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_mode = 1'b0; a = '0; b = '0;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("reset_out_valid", 64'(out_valid), 0);
      checkOutput("reset_in_ready", 64'(in_ready), 1);
      checkOutput("reset_y", longint'(y), 0);
      checkOutput("reset_sat", 64'(sat), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].rnd, yv, sv, y2v, s2v, lat);
         checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 3);
         checkOutput($sformatf("vec%0d_y", i), yv, vecs[i].y9);
         checkOutput($sformatf("vec%0d_sat", i), 64'(sv), 64'(vecs[i].sat9));
         checkOutput($sformatf("vec%0d_y_ow18", i), y2v, vecs[i].y18);
         checkOutput($sformatf("vec%0d_sat_ow18", i), 64'(s2v), 64'(vecs[i].sat18));
      end

      for (int i = 0; i < 20; i++) begin
         sa[i] = int'($urandom_range(0, 511)) - 256;
         sb[i] = int'($urandom_range(0, 511)) - 256;
         sr[i] = 1'($urandom_range(0, 1));
      end
      idx = 0; guard = 0; popped = 0;
      while ((idx < 20 || expQ.size() > 0) && guard < 600) begin
         if (idx < 20) stepCycle(1'b1, sa[idx], sb[idx], sr[idx], 1'($urandom_range(0, 1)), acc);
         else          stepCycle(1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)), acc);
         if (acc) idx++;
         guard++;
      end
      checkOutput("stream_accepted", 64'(idx), 20);
      checkOutput("stream_popped", 64'(popped), 20);

      stepCycle(1'b1, 100, -77, 1'b1, 1'b0, acc);
      repeat (3) stepCycle(1'b0, 0, 0, 1'b0, 1'b0, acc);
      checkOutput("bubble_s3_valid", 64'(out_valid), 1);
      stepCycle(1'b1, -200, 150, 1'b0, 1'b0, acc);
      checkOutput("bubble_accept_first", 64'(acc), 1);
      stepCycle(1'b1, 33, 44, 1'b1, 1'b0, acc);
      checkOutput("bubble_accept_second", 64'(acc), 1);
      stepCycle(1'b1, -5, 99, 1'b0, 1'b0, acc);
      checkOutput("bubble_full_blocks", 64'(acc), 0);
      guard = 0;
      while (!acc && guard < 20) begin
         stepCycle(1'b1, -5, 99, 1'b0, 1'b1, acc);
         guard++;
      end
      guard = 0;
      while (expQ.size() > 0 && guard < 50) begin
         stepCycle(1'b0, 0, 0, 1'b0, 1'b1, acc);
         guard++;
      end
      checkOutput("bubble_drained", 64'(expQ.size()), 0);

      stepCycle(1'b1, 127, 127, 1'b0, 1'b0, acc);
      stepCycle(1'b1, -128, 3, 1'b1, 1'b0, acc);
      stepCycle(1'b1, 7, -9, 1'b0, 1'b0, acc);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("midreset_full_in_ready", 64'(in_ready), 0);
      checkOutput("midreset_full_valid", 64'(out_valid), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_out_valid", 64'(out_valid), 0);
      checkOutput("midreset_in_ready", 64'(in_ready), 1);
      checkOutput("midreset_y", longint'(y), 0);
      expQ.delete();
      prevStalled = 1'b0;
      applyStimulus(64, -64, 1'b0, yv, sv, y2v, s2v, lat);
      checkOutput("postreset_latency", 64'(lat), 3);
      checkOutput("postreset_y", yv, -64);
      checkOutput("postreset_sat", 64'(sv), 0);
      repeat (5) stepCycle(1'b0, 0, 0, 1'b0, 1'b1, acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/signed_fxp_mult_pipe.md
Name: signed_fxp_mult_pipe

Overview:
- Parametrised, pipelined signed two's-complement fixed-point multiplier for the conv datapath.
- Computes a*b with arithmetic rescale by FRAC bits, selectable rounding, and saturation to the output width.
- Three-stage pipeline with valid/ready handshake on both sides and full backpressure support.
- Sits between the pixel/weight fetch logic and the conv accumulator; one product per cycle when unstalled.

Parameters:
- DW, 9, input operand width, signed two's complement; legal range 2..32.
- FRAC, 6, fractional bits per operand; product is shifted right by FRAC; legal range 0..DW-1.
- OW, 9, output width, signed; legal range 2..2*DW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  DW  signed multiplicand
- b  in  DW  signed multiplier
- rnd_mode  in  1  0 = truncate (floor), 1 = round half up; sampled with the operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  OW  signed rescaled, saturated product
- sat  out  1  y was clipped, qualified by out_valid

Behaviour:
- Reset: on a clk edge with rst=1, all stage valid bits clear. out_valid=0, y=0, sat=0, in_ready=1 in the following cycle. A reset mid-stream discards every in-flight item without emitting it. rst has priority over all handshakes.
- Transfers: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- S1 registers a, b and rnd_mode.
- S2 registers the full 2*DW-bit signed product. It is exact for all inputs, including (-2^(DW-1))^2.
- S3 computes and registers y and sat:
  - bias = rnd_mode ? 2^(FRAC-1) : 0; bias = 0 when FRAC = 0.
  - r = (p + bias) >>> FRAC, arithmetic shift, computed at 2*DW+1 bits so bias cannot overflow.
  - If r > 2^(OW-1)-1, then y = 2^(OW-1)-1 and sat = 1.
  - If r < -2^(OW-1), then y = -2^(OW-1) and sat = 1.
  - Otherwise y = r[OW-1:0] and sat = 0.
- Latency: exactly 3 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 result per cycle when out_ready=1.
- Stall rule: each stage advances when it is empty or the next stage advances.
  - adv3 = ~v3 | out_ready
  - adv2 = ~v2 | adv3
  - adv1 = ~v1 | adv2
  - in_ready = adv1
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- While out_valid=1 and out_ready=0: y, sat and out_valid hold stable, and no data is lost or duplicated.
- Simultaneous input and output transfer in the same cycle with a full pipe is legal; the pipe shifts by one.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- Stage data registers may load only when the stage advances. Data is don't-care when the stage is invalid, but y=0 after reset.

Test Plan (DW=9, FRAC=6, OW=9 unless stated):
- Basic: a=64, b=64, rnd=0 -> y=64, sat=0, out_valid exactly 3 cycles after the input transfer. Also a=96, b=-32 -> y=-48.
- Rounding: a=1, b=32 gives y=0 with rnd=0 and y=1 with rnd=1. a=-1, b=32 gives y=-1 with rnd=0 and y=0 with rnd=1. a=-1, b=-64 gives y=1 with both modes.
- Saturation: a=-256, b=-256 -> y=255, sat=1. a=-256, b=255 -> y=-256 (exact, r=-1020 clipped), sat=1. a=255, b=64 -> y=255, sat=0. Rerun with OW=18: a=-256, b=-256 -> y=1024, sat=0.
- Backpressure: stream 20 random operand pairs back-to-back while out_ready toggles pseudo-randomly. Check in-order, lossless, duplicate-free results against the golden model. Check y/sat stable while stalled. Check in_ready=0 only when all 3 stages are full and out_ready=0.
- Reset mid-operation: load 3 items with out_ready=0, then assert rst for 1 cycle. Next cycle: out_valid=0, in_ready=1, y=0. Then a new item a=64, b=-64 -> y=-64 after 3 cycles; no stale item appears.
- Bubble collapse: hold out_ready=0 with one item in S3, then present 2 new items. Both are accepted on consecutive cycles, and in_ready drops only after S1 fills.
